// File: rtl/toggle_counter.sv
// toggle_counter: WIDTH-bit up/down counter built from T flip-flop stages.
// Counts between 0 and MAX, either wrapping or saturating at the ends, with
// synchronous clear/load, a one-cycle terminal-count pulse (tc) and a T
// flip-flop (div_out) that toggles on every terminal-count event.
// Every output is registered, so no input reaches an output combinationally.
module toggle_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX       = 9,
   parameter bit SATURATE  = 1'b0,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             div_out
);

   // The terminal value, the reset value and the count step, all as
   // WIDTH-bit unsigned constants. Arithmetic on the count stays inside
   // WIDTH bits, so MAX = 2**WIDTH-1 wraps without needing a carry bit.
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   // Decoded conditions on the current count.
   logic             at_top;
   logic             at_bottom;
   logic             over_max;

   // Value the count should hold after this edge, and the per-stage toggle
   // mask that gets it there.
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] t;

   // Next values of the flag outputs.
   logic             tc_next;
   logic             div_toggle;

   // Clamped load value: anything past MAX is taken as MAX.
   logic [WIDTH-1:0] load_clamped;

   // Decode where the count sits relative to its two boundaries.
   always_comb begin
      at_top       = (q == MAX_V);
      at_bottom    = (q == '0);
      over_max     = (q > MAX_V);
      load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
   end

   // Pick the next count with clr > load > en priority. The terminal event
   // happens only when counting into a boundary, never on clr or load.
   always_comb begin
      q_next     = q;
      tc_next    = 1'b0;
      div_toggle = 1'b0;
      if (clr) begin
         q_next = '0;
      end else if (load) begin
         q_next = load_clamped;
      end else if (en) begin
         if (up) begin
            if (over_max) begin
               q_next = '0;
            end else if (at_top) begin
               tc_next    = 1'b1;
               div_toggle = 1'b1;
               q_next     = SATURATE ? MAX_V : '0;
            end else begin
               q_next = q + ONE_V;
            end
         end else begin
            if (over_max) begin
               q_next = MAX_V;
            end else if (at_bottom) begin
               tc_next    = 1'b1;
               div_toggle = 1'b1;
               q_next     = SATURATE ? '0 : MAX_V;
            end else begin
               q_next = q - ONE_V;
            end
         end
      end
   end

   // Each counter bit is a T flip-flop; its t input is set wherever the
   // current and next counts differ.
   always_comb begin
      t = q ^ q_next;
   end

   // Counter stages: toggle the bits selected by t; reset to RESET_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_V;
      end else begin
         q <= q ^ t;
      end
   end

   // Terminal-count pulse and the divided output, cleared by reset only;
   // clr and load leave div_out where it is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc      <= 1'b0;
         div_out <= 1'b0;
      end else begin
         tc      <= tc_next;
         div_out <= div_out ^ div_toggle;
      end
   end

endmodule

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: directed self-checking bench for toggle_counter.
// Three instances share clk and rst_n: the default wrapping counter
// (WIDTH=4, MAX=9), a saturating copy, and a full-range WIDTH=3, MAX=7 copy.
module tb_toggle_counter;

   logic       clk;
   logic       rst_n;

   // Instance m: WIDTH=4, MAX=9, wrap
   logic       m_clr, m_load, m_en, m_up;
   logic [3:0] m_load_val;
   logic [3:0] m_q;
   logic       m_tc, m_div;

   // Instance s: WIDTH=4, MAX=9, saturate
   logic       s_clr, s_load, s_en, s_up;
   logic [3:0] s_load_val;
   logic [3:0] s_q;
   logic       s_tc, s_div;

   // Instance w: WIDTH=3, MAX=7, wrap
   logic       w_clr, w_load, w_en, w_up;
   logic [2:0] w_load_val;
   logic [2:0] w_q;
   logic       w_tc, w_div;

   int checks;
   int errors;

   toggle_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .RESET_VAL(0)) dut_m (
      .clk(clk), .rst_n(rst_n), .clr(m_clr), .load(m_load), .load_val(m_load_val),
      .en(m_en), .up(m_up), .q(m_q), .tc(m_tc), .div_out(m_div));

   toggle_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .RESET_VAL(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .clr(s_clr), .load(s_load), .load_val(s_load_val),
      .en(s_en), .up(s_up), .q(s_q), .tc(s_tc), .div_out(s_div));

   toggle_counter #(.WIDTH(3), .MAX(7), .SATURATE(1'b0), .RESET_VAL(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .clr(w_clr), .load(w_load), .load_val(w_load_val),
      .en(w_en), .up(w_up), .q(w_q), .tc(w_tc), .div_out(w_div));

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset state, async reset mid-count, and first count after release.
   task automatic test_reset();
      checks++; if (m_q !== 4'd0) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", m_q); end
      checks++; if (m_tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc: got %b expected 0", m_tc); end
      checks++; if (m_div !== 1'b0) begin errors++; $display("[TB] FAIL reset_div: got %b expected 0", m_div); end
      checks++; if (s_q !== 4'd0) begin errors++; $display("[TB] FAIL reset_sat_q: got %0d expected 0", s_q); end
      checks++; if (w_q !== 3'd0) begin errors++; $display("[TB] FAIL reset_w3_q: got %0d expected 0", w_q); end
      @(negedge clk);
      rst_n = 1'b1;
      m_en  = 1'b1;
      m_up  = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (m_q !== 4'd5) begin errors++; $display("[TB] FAIL precount_q: got %0d expected 5", m_q); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (m_q !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_q: got %0d expected 0", m_q); end
      checks++; if (m_tc !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_tc: got %b expected 0", m_tc); end
      checks++; if (m_div !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_div: got %b expected 0", m_div); end
      #1;
      rst_n = 1'b1;
      tick();
      checks++; if (m_q !== 4'd1) begin errors++; $display("[TB] FAIL post_release_q: got %0d expected 1", m_q); end
   endtask

   // 24 up counts from 0: q follows k mod 10, tc after each 9->0, div 0->1->0.
   task automatic test_wrap_up();
      int pulses;
      pulses = 0;
      m_en  = 1'b0;
      m_clr = 1'b1;
      tick();
      checks++; if (m_q !== 4'd0) begin errors++; $display("[TB] FAIL clr_to_zero_q: got %0d expected 0", m_q); end
      m_clr = 1'b0;
      m_en  = 1'b1;
      m_up  = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (m_tc === 1'b1) pulses++;
         checks++; if (m_q !== 4'(k % 10)) begin errors++; $display("[TB] FAIL wrap_up_q[%0d]: got %0d expected %0d", k, m_q, k % 10); end
         checks++; if (m_tc !== (k % 10 == 0)) begin errors++; $display("[TB] FAIL wrap_up_tc[%0d]: got %b expected %b", k, m_tc, (k % 10 == 0)); end
         checks++; if (m_div !== (k >= 10 && k < 20)) begin errors++; $display("[TB] FAIL wrap_up_div[%0d]: got %b expected %b", k, m_div, (k >= 10 && k < 20)); end
      end
      checks++; if (pulses != 2) begin errors++; $display("[TB] FAIL wrap_up_pulses: got %0d expected 2", pulses); end
      m_en = 1'b0;
   endtask

   // From 2 count down through the 0->9 wrap, then flip up through 9->0.
   task automatic test_wrap_down_flip();
      int eq [6];
      int et [6];
      int ed [6];
      eq = '{1, 0, 9, 8, 9, 0};
      et = '{0, 0, 1, 0, 0, 1};
      ed = '{0, 0, 1, 1, 1, 0};
      m_load     = 1'b1;
      m_load_val = 4'd2;
      tick();
      checks++; if (m_q !== 4'd2) begin errors++; $display("[TB] FAIL load2_q: got %0d expected 2", m_q); end
      m_load = 1'b0;
      m_en   = 1'b1;
      m_up   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) m_up = 1'b1;
         tick();
         checks++; if (m_q !== 4'(eq[i])) begin errors++; $display("[TB] FAIL down_flip_q[%0d]: got %0d expected %0d", i, m_q, eq[i]); end
         checks++; if (m_tc !== 1'(et[i])) begin errors++; $display("[TB] FAIL down_flip_tc[%0d]: got %b expected %0d", i, m_tc, et[i]); end
         checks++; if (m_div !== 1'(ed[i])) begin errors++; $display("[TB] FAIL down_flip_div[%0d]: got %b expected %0d", i, m_div, ed[i]); end
      end
      m_en = 1'b0;
   endtask

   // load beats en, clamps above MAX, and clr beats load; en=0 holds.
   task automatic test_load_clr();
      m_en       = 1'b1;
      m_up       = 1'b1;
      m_load     = 1'b1;
      m_load_val = 4'd7;
      tick();
      checks++; if (m_q !== 4'd7) begin errors++; $display("[TB] FAIL load7_q: got %0d expected 7", m_q); end
      checks++; if (m_tc !== 1'b0) begin errors++; $display("[TB] FAIL load7_tc: got %b expected 0", m_tc); end
      m_load_val = 4'd14;
      tick();
      checks++; if (m_q !== 4'd9) begin errors++; $display("[TB] FAIL load14_clamp_q: got %0d expected 9", m_q); end
      m_load_val = 4'd3;
      tick();
      checks++; if (m_q !== 4'd3) begin errors++; $display("[TB] FAIL load_at_max_q: got %0d expected 3", m_q); end
      checks++; if (m_tc !== 1'b0) begin errors++; $display("[TB] FAIL load_at_max_tc: got %b expected 0", m_tc); end
      checks++; if (m_div !== 1'b0) begin errors++; $display("[TB] FAIL load_at_max_div: got %b expected 0", m_div); end
      m_load_val = 4'd9;
      tick();
      m_clr      = 1'b1;
      m_load_val = 4'd5;
      tick();
      checks++; if (m_q !== 4'd0) begin errors++; $display("[TB] FAIL clr_over_load_q: got %0d expected 0", m_q); end
      checks++; if (m_tc !== 1'b0) begin errors++; $display("[TB] FAIL clr_over_load_tc: got %b expected 0", m_tc); end
      checks++; if (m_div !== 1'b0) begin errors++; $display("[TB] FAIL clr_over_load_div: got %b expected 0", m_div); end
      m_clr  = 1'b0;
      m_load = 1'b0;
      m_en   = 1'b0;
      tick();
      checks++; if (m_q !== 4'd0) begin errors++; $display("[TB] FAIL hold_q: got %0d expected 0", m_q); end
   endtask

   // Saturating instance: hold at 9 with tc every cycle, then hold at 0.
   task automatic test_saturate();
      int eq [9];
      int et [9];
      int ed [9];
      logic eup [9];
      eq  = '{9, 9, 9, 9, 8, 1, 0, 0, 0};
      et  = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
      ed  = '{0, 1, 0, 1, 1, 1, 1, 0, 1};
      eup = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      s_load     = 1'b1;
      s_load_val = 4'd8;
      tick();
      checks++; if (s_q !== 4'd8) begin errors++; $display("[TB] FAIL sat_load8_q: got %0d expected 8", s_q); end
      s_load = 1'b0;
      s_en   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         s_up = eup[i];
         if (i == 5) begin
            s_load     = 1'b1;
            s_load_val = 4'd1;
         end else begin
            s_load = 1'b0;
         end
         tick();
         checks++; if (s_q !== 4'(eq[i])) begin errors++; $display("[TB] FAIL sat_q[%0d]: got %0d expected %0d", i, s_q, eq[i]); end
         checks++; if (s_tc !== 1'(et[i])) begin errors++; $display("[TB] FAIL sat_tc[%0d]: got %b expected %0d", i, s_tc, et[i]); end
         checks++; if (s_div !== 1'(ed[i])) begin errors++; $display("[TB] FAIL sat_div[%0d]: got %b expected %0d", i, s_div, ed[i]); end
      end
      s_en = 1'b0;
      tick();
      checks++; if (s_tc !== 1'b0) begin errors++; $display("[TB] FAIL sat_idle_tc: got %b expected 0", s_tc); end
      checks++; if (s_q !== 4'd0) begin errors++; $display("[TB] FAIL sat_idle_q: got %0d expected 0", s_q); end
   endtask

   // WIDTH=3, MAX=7: two clean 7->0 wraps, then enable gaps that hold q.
   task automatic test_full_range();
      int   eq [11];
      int   et [11];
      int   ed [11];
      logic een [11];
      eq  = '{1, 2, 3, 3, 3, 4, 5, 6, 7, 0, 0};
      et  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      ed  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      een = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      w_en = 1'b1;
      w_up = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++; if (w_q !== 3'(k % 8)) begin errors++; $display("[TB] FAIL w3_q[%0d]: got %0d expected %0d", k, w_q, k % 8); end
         checks++; if (w_tc !== (k % 8 == 0)) begin errors++; $display("[TB] FAIL w3_tc[%0d]: got %b expected %b", k, w_tc, (k % 8 == 0)); end
         checks++; if (w_div !== (k >= 8 && k < 16)) begin errors++; $display("[TB] FAIL w3_div[%0d]: got %b expected %b", k, w_div, (k >= 8 && k < 16)); end
      end
      for (int i = 0; i < 11; i++) begin
         w_en = een[i];
         tick();
         checks++; if (w_q !== 3'(eq[i])) begin errors++; $display("[TB] FAIL w3_gap_q[%0d]: got %0d expected %0d", i, w_q, eq[i]); end
         checks++; if (w_tc !== 1'(et[i])) begin errors++; $display("[TB] FAIL w3_gap_tc[%0d]: got %b expected %0d", i, w_tc, et[i]); end
         checks++; if (w_div !== 1'(ed[i])) begin errors++; $display("[TB] FAIL w3_gap_div[%0d]: got %b expected %0d", i, w_div, ed[i]); end
      end
      w_en = 1'b0;
   endtask

   // Run every scenario in order and report the totals.
   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      m_clr      = 1'b0; m_load = 1'b0; m_en = 1'b0; m_up = 1'b1; m_load_val = 4'd0;
      s_clr      = 1'b0; s_load = 1'b0; s_en = 1'b0; s_up = 1'b1; s_load_val = 4'd0;
      w_clr      = 1'b0; w_load = 1'b0; w_en = 1'b0; w_up = 1'b1; w_load_val = 3'd0;
      #2;
      test_reset();
      test_wrap_up();
      test_wrap_down_flip();
      test_load_clr();
      test_saturate();
      test_full_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so the run always ends even if the scenario sequence stalls.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete within 100000 time units");
      $fatal(1, "[TB] timeout");
   end

endmodule
